// File: rtl/sync_fifo_pkg.sv
// Shared constants and helpers for the parametrised single-clock FIFO.
// Width-independent pointer arithmetic is done at the 13-bit maximum.
package sync_fifo_pkg;

   localparam int PTR_MAX_W = 13;

   typedef logic [PTR_MAX_W-1:0] ptr_max_t;

   localparam int DEF_AEMPTY_LEVEL = 4;
   localparam int DEF_AFULL_MARGIN = 4;

   localparam int ERR_W       = 2;
   localparam int ERR_OVF_BIT = 0;
   localparam int ERR_UDF_BIT = 1;

   function automatic int clog2(input int unsigned n);
      int r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(n)) begin
            r = i + 1;
         end
      end
      return r;
   endfunction

   // Occupancy modulo 2^(aw+1); wrap bits make this exact up to full.
   function automatic ptr_max_t level_of(
      input ptr_max_t    wp,
      input ptr_max_t    rp,
      input int unsigned aw
   );
      ptr_max_t mask;
      mask = ptr_max_t'((32'd1 << (aw + 1)) - 32'd1);
      return (wp - rp) & mask;
   endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Simple dual-port RAM, one write port and one registered read port.
// Written for SB_RAM40_4K inference, so the data array has no reset.
module sync_fifo_ram
   import sync_fifo_pkg::*;
#(
   parameter  int DW    = 8,
   parameter  int DEPTH = 512,
   localparam int AW    = clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [DW-1:0] wdata_i,
   input  logic          re_i,
   input  logic [AW-1:0] raddr_i,
   output logic [DW-1:0] rdata_o
);

   logic [DW-1:0] mem_q [DEPTH];
   logic [DW-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   always_ff @(posedge clk) begin
      if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/sync_fifo.sv
// Parametrised single-clock FIFO with registered level and flags.
// Define SYNC_FIFO_FWFT_EN for first-word fall-through output.
module sync_fifo
   import sync_fifo_pkg::*;
#(
   parameter int DATA_WIDTH   = 8,
   parameter int ADDR_WIDTH   = 9,
   parameter int AFULL_LEVEL  =
      (1 << ADDR_WIDTH) - DEF_AFULL_MARGIN,
   parameter int AEMPTY_LEVEL = DEF_AEMPTY_LEVEL
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr,
   input  logic                  we,
   input  logic [DATA_WIDTH-1:0] d,
   input  logic                  re,
   output logic [DATA_WIDTH-1:0] q,
   output logic                  empty,
   output logic                  full,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [ADDR_WIDTH:0]   level,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam int PW    = ADDR_WIDTH + 1;

   localparam logic [PW-1:0] AFULL_L  = PW'(AFULL_LEVEL);
   localparam logic [PW-1:0] AEMPTY_L = PW'(AEMPTY_LEVEL);

   logic [PW-1:0]         wptr_q, wptr_d;
   logic [PW-1:0]         rptr_q, rptr_d;
   logic [PW-1:0]         level_q, level_d;
   logic                  empty_q, empty_d;
   logic                  full_q, full_d;
   logic                  afull_q, afull_d;
   logic                  aempty_q, aempty_d;
   logic [ERR_W-1:0]      err_q, err_d;
   logic                  qv_q, qv_d;

   logic                  wr_ok;
   logic                  rd_ok;
   logic                  ram_we;
   logic                  ram_re;
   logic                  held_d;
   logic [DATA_WIDTH-1:0] ram_rdata;

   assign wr_ok  = we & ~full_q;
   assign rd_ok  = re & ~empty_q;
   assign ram_we = wr_ok & ~clr;

`ifdef SYNC_FIFO_FWFT_EN
   localparam logic [PW-1:0] DEPTH_L = PW'(DEPTH);

   logic ram_avail;

   // Prefetch whenever the output register is free or being consumed.
   assign ram_avail = (wptr_q != rptr_q);
   assign ram_re    = ~clr & ram_avail & (~qv_q | rd_ok);
   assign qv_d      = ~clr & (ram_re | (qv_q & ~rd_ok));
   assign held_d    = qv_d;
`else
   assign ram_re = rd_ok & ~clr;
   assign qv_d   = qv_q | ram_re;
   assign held_d = 1'b0;
`endif

   always_comb begin
      wptr_d = wptr_q + PW'(wr_ok);
      rptr_d = rptr_q + PW'(ram_re);
      err_d  = err_q;
      if (we & full_q) begin
         err_d[ERR_OVF_BIT] = 1'b1;
      end
      if (re & empty_q) begin
         err_d[ERR_UDF_BIT] = 1'b1;
      end
      if (clr) begin
         wptr_d = '0;
         rptr_d = '0;
         err_d  = '0;
      end
   end

   always_comb begin
      level_d = PW'(
         level_of(
            ptr_max_t'(wptr_d),
            ptr_max_t'(rptr_d),
            ADDR_WIDTH
         ) + ptr_max_t'(held_d)
      );
`ifdef SYNC_FIFO_FWFT_EN
      empty_d = ~qv_d;
      full_d  = (level_d == DEPTH_L);
`else
      empty_d = (wptr_d == rptr_d);
      full_d  =
         (wptr_d[ADDR_WIDTH] != rptr_d[ADDR_WIDTH]) &&
         (wptr_d[ADDR_WIDTH-1:0] == rptr_d[ADDR_WIDTH-1:0]);
`endif
      afull_d  = (level_d >= AFULL_L);
      aempty_d = (level_d <= AEMPTY_L);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q   <= '0;
         rptr_q   <= '0;
         level_q  <= '0;
         empty_q  <= 1'b1;
         full_q   <= 1'b0;
         afull_q  <= 1'b0;
         aempty_q <= 1'b1;
         err_q    <= '0;
         qv_q     <= 1'b0;
      end else begin
         wptr_q   <= wptr_d;
         rptr_q   <= rptr_d;
         level_q  <= level_d;
         empty_q  <= empty_d;
         full_q   <= full_d;
         afull_q  <= afull_d;
         aempty_q <= aempty_d;
         err_q    <= err_d;
         qv_q     <= qv_d;
      end
   end

   sync_fifo_ram #(
      .DW    (DATA_WIDTH),
      .DEPTH (DEPTH)
   ) u_ram (
      .clk     (clk),
      .we_i    (ram_we),
      .waddr_i (wptr_q[ADDR_WIDTH-1:0]),
      .wdata_i (d),
      .re_i    (ram_re),
      .raddr_i (rptr_q[ADDR_WIDTH-1:0]),
      .rdata_o (ram_rdata)
   );

   // RAM output is unreset; mask it until a word has been read.
   assign q            = qv_q ? ram_rdata : '0;
   assign empty        = empty_q;
   assign full         = full_q;
   assign almost_full  = afull_q;
   assign almost_empty = aempty_q;
   assign level        = level_q;
   assign overflow     = err_q[ERR_OVF_BIT];
   assign underflow    = err_q[ERR_UDF_BIT];

endmodule
